reset_sequencer: RTL and testbench
==================================

// Module: reset_sequencer
// PURPOSE
// Takes the board-level asynchronous active-low Reset and releases NUM_STAGES downstream
// active-low resets one after another, each held HOLD_CYCLES clocks after the previous one.
// Also accepts a one-cycle software reset request and acknowledges it when the full
// release sequence has finished. Sits between the reset pin and the counter/datapath blocks.
// PARAMETERS
// NUM_STAGES   3    number of sequenced reset outputs (>=1)
// HOLD_CYCLES  16   clocks between successive releases (>=1, <= 2**CNT_W)
// CNT_W        8    hold-counter width
// PORTS
// Clock      in   1           system clock, rising edge
// Reset      in   1           asynchronous active-low reset
// Soft_req   in   1           one-cycle software reset request pulse
// Soft_ack   out  1           one-cycle pulse: software sequence complete
// Rst_n_out  out  NUM_STAGES  sequenced active-low resets; bit 0 released first
// Ready      out  1           high when all stages released (RUN state)
// BEHAVIOUR
// - Reset low: asynchronously Rst_n_out=0, Ready=0, Soft_ack=0, 2-flop sync chain=0,
//   counter=0, stage index=0, state=HOLD. Applies at any time, including mid-sequence.
// - Internal sync: 2 flops, async clear, D=1; output high after 2nd rising edge (E2)
//   following Reset release. FSM and counter are frozen while sync output is low.
// - States: HOLD (all outputs asserted, counting), RELEASE (some stages released,
//   counting), RUN (all released). HOLD->RELEASE on first release; RELEASE->RUN on last.
// - Counter counts 0..HOLD_CYCLES-1; on terminal count: clear counter, drive
//   Rst_n_out[stage]=1, increment stage index. Released bits stay high until reset/soft req.
// - Power-up timing (reference edge R=E2): Rst_n_out[k] rises at edge R+(k+1)*HOLD_CYCLES.
//   Ready rises at the same edge as Rst_n_out[NUM_STAGES-1] (R+NUM_STAGES*HOLD_CYCLES).
// - Soft_req sampled only in RUN. Sampling edge S: Rst_n_out=0, Ready=0, counter=0,
//   stage=0, state=HOLD, soft_pending=1. Timing then identical with R replaced by S.
// - Soft_ack: one-cycle pulse coincident with Ready rising, only when soft_pending=1;
//   clears soft_pending. No Soft_ack after power-up/async reset sequence.
// - Soft_req while in HOLD/RELEASE: ignored, no ack, sequence timing unchanged.
// - Soft_req high on two consecutive RUN cycles: cannot occur (first pulse leaves RUN).
// - Soft_req high on the edge Ready rises: ignored (state not yet RUN when sampled).
// - Async Reset during soft sequence: soft_pending cleared; no Soft_ack will follow.
// - All outputs registered; no combinational path from inputs to outputs.
// TESTING (defaults NUM_STAGES=3, HOLD_CYCLES=16)
// 1. Reset low 5 cycles then high -> Rst_n_out=000 through E17; 001 at E18, 011 at E34,
//    111 and Ready=1 at E50; Soft_ack stays 0 throughout.
// 2. In RUN pulse Soft_req at edge S -> Rst_n_out=000, Ready=0 at S; 001 at S+16,
//    011 at S+32, 111 with Ready=1 and Soft_ack=1 (one cycle) at S+48.
// 3. Soft_req pulses at S+5 and at S+48 during a soft sequence -> ignored; only one
//    Soft_ack at S+48; Ready stays 1 afterwards.
// 4. Reset driven low mid-clock at S+40 (outputs 011) -> Rst_n_out=000 immediately without
//    a clock edge; after release, full power-up timing repeats, no Soft_ack.
// 5. Reset glitch low <1 cycle in RUN -> outputs 000 asynchronously, resync restarts at E1/E2.
// 6. Params NUM_STAGES=1, HOLD_CYCLES=1 -> Rst_n_out=1 and Ready=1 at E3; soft req at S
//    -> Soft_ack at S+1.

Source files
------------

// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Synchronises the board-level asynchronous active-low Reset and releases
//   NUM_STAGES downstream active-low resets one after another. Each release
//   comes HOLD_CYCLES clocks after the previous one. A one-cycle software
//   request accepted in RUN reruns the sequence. Soft_ack pulses when that
//   rerun completes.
//
// Ports
//   Clock      in   system clock, rising edge
//   Reset      in   asynchronous active-low reset
//   Soft_req   in   one-cycle software reset request, sampled only in RUN
//   Soft_ack   out  one-cycle pulse when a software sequence completes
//   Rst_n_out  out  [NUM_STAGES] sequenced active-low resets, bit 0 first
//   Ready      out  high when every stage is released (RUN)
module reset_sequencer #(
  parameter int NUM_STAGES  = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int CNT_W       = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Soft_req,
  output logic                  Soft_ack,
  output logic [NUM_STAGES-1:0] Rst_n_out,
  output logic                  Ready
);

  localparam int STG_W = (NUM_STAGES < 2) ? 1 : $clog2(NUM_STAGES + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [STG_W-1:0] STG_LAST = STG_W'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0]              sync_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [STG_W-1:0]        stage_q, stage_d;
  logic [NUM_STAGES-1:0]   rst_n_q, rst_n_d;
  logic                    ack_q, ack_d;
  logic                    pending_q, pending_d;

  // The two-flop synchroniser only ever clears asynchronously. Its output
  // enables the sequencer, so the FSM starts counting at the edge after E2.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  // State register. The outputs are computed in always_comb and are
  // registered here, so no input reaches an output combinationally.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= S_HOLD;
      cnt_q     <= '0;
      stage_q   <= '0;
      rst_n_q   <= '0;
      ack_q     <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stage_q   <= stage_d;
      rst_n_q   <= rst_n_d;
      ack_q     <= ack_d;
      pending_q <= pending_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stage_d   = stage_q;
    rst_n_d   = rst_n_q;
    ack_d     = 1'b0;
    pending_d = pending_q;

    if (sync_q[1]) begin
      unique case (state_q)
        S_HOLD, S_RELEASE: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            stage_d = stage_q + STG_W'(1);
            for (int unsigned i = 0; i < NUM_STAGES; i++) begin
              if (stage_q == STG_W'(i)) rst_n_d[i] = 1'b1;
            end
            if (stage_q == STG_LAST) begin
              state_d   = S_RUN;
              ack_d     = pending_q;
              pending_d = 1'b0;
            end else begin
              state_d = S_RELEASE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_RUN: begin
          if (Soft_req) begin
            state_d   = S_HOLD;
            cnt_d     = '0;
            stage_d   = '0;
            rst_n_d   = '0;
            pending_d = 1'b1;
          end
        end
        default: state_d = S_HOLD;
      endcase
    end
  end

  // Output decode. Ready comes straight from the state register.
  always_comb begin
    Rst_n_out = rst_n_q;
    Soft_ack  = ack_q;
    Ready     = (state_q == S_RUN);
  end

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

  logic       clk;
  logic       rst_a, req_a, ack_a, rdy_a;
  logic [2:0] out_a;
  logic       rst_b, req_b, ack_b, rdy_b;
  logic [0:0] out_b;

  int vectors;
  int errors;

  reset_sequencer #(.NUM_STAGES(3), .HOLD_CYCLES(16), .CNT_W(8)) dut_a (
    .Clock(clk), .Reset(rst_a), .Soft_req(req_a),
    .Soft_ack(ack_a), .Rst_n_out(out_a), .Ready(rdy_a)
  );

  reset_sequencer #(.NUM_STAGES(1), .HOLD_CYCLES(1), .CNT_W(8)) dut_b (
    .Clock(clk), .Reset(rst_b), .Soft_req(req_b),
    .Soft_ack(ack_b), .Rst_n_out(out_b), .Ready(rdy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and sample 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] exp_out(input int k);
    if (k >= 48)      return 3'b111;
    else if (k >= 32) return 3'b011;
    else if (k >= 16) return 3'b001;
    else              return 3'b000;
  endfunction

  // The caller has just released rst_a between edges. The next edge is E1,
  // and E2 is the reference edge, so the expected pattern uses k = e - 2.
  task automatic check_powerup(input string name);
    for (int e = 1; e <= 55; e++) begin
      tick();
      vectors++;
      if (out_a !== exp_out(e - 2) || rdy_a !== (e >= 50) || ack_a !== 1'b0) begin
        errors++;
        $display("FAIL %s E%0d: out=%b rdy=%b ack=%b, expected out=%b rdy=%b ack=0",
                 name, e, out_a, rdy_a, ack_a, exp_out(e - 2), (e >= 50));
      end
    end
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1; req_a = 1'b0; req_b = 1'b0;
    #1;
    rst_a = 1'b0; rst_b = 1'b0;
    #1;
    vectors++;
    if (out_a !== 3'b000 || rdy_a !== 1'b0 || ack_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_a: out=%b rdy=%b ack=%b, expected 000/0/0", out_a, rdy_a, ack_a);
    end
    vectors++;
    if (out_b !== 1'b0 || rdy_b !== 1'b0 || ack_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_b: out=%b rdy=%b ack=%b, expected 0/0/0", out_b, rdy_b, ack_b);
    end
  endtask

  task automatic test_powerup();
    repeat (5) tick();
    rst_a = 1'b1;
    check_powerup("powerup");
  endtask

  // A soft sequence from RUN. With extra set, it also fires ignored requests
  // at S+5 (HOLD) and at S+48 (the edge where Ready rises).
  task automatic test_soft(input bit extra, input string name);
    req_a = 1'b1;
    tick();                       // edge S
    req_a = 1'b0;
    vectors++;
    if (out_a !== 3'b000 || rdy_a !== 1'b0 || ack_a !== 1'b0) begin
      errors++;
      $display("FAIL %s S+0: out=%b rdy=%b ack=%b, expected 000/0/0", name, out_a, rdy_a, ack_a);
    end
    for (int k = 1; k <= 52; k++) begin
      if (extra && (k == 5 || k == 48)) req_a = 1'b1;
      tick();
      req_a = 1'b0;
      vectors++;
      if (out_a !== exp_out(k) || rdy_a !== (k >= 48) || ack_a !== (k == 48)) begin
        errors++;
        $display("FAIL %s S+%0d: out=%b rdy=%b ack=%b, expected out=%b rdy=%b ack=%b",
                 name, k, out_a, rdy_a, ack_a, exp_out(k), (k >= 48), (k == 48));
      end
    end
  endtask

  task automatic test_reset_mid_soft();
    req_a = 1'b1;
    tick();
    req_a = 1'b0;
    repeat (40) tick();           // now at S+40, outputs 011
    vectors++;
    if (out_a !== 3'b011) begin
      errors++;
      $display("FAIL midsoft_pre: out=%b, expected 011", out_a);
    end
    #2 rst_a = 1'b0;
    #1;
    vectors++;
    if (out_a !== 3'b000 || rdy_a !== 1'b0 || ack_a !== 1'b0) begin
      errors++;
      $display("FAIL midsoft_async: out=%b rdy=%b ack=%b, expected 000/0/0", out_a, rdy_a, ack_a);
    end
    repeat (3) tick();
    rst_a = 1'b1;
    check_powerup("midsoft_repeat");
  endtask

  task automatic test_glitch();
    vectors++;
    if (out_a !== 3'b111 || rdy_a !== 1'b1) begin
      errors++;
      $display("FAIL glitch_pre: out=%b rdy=%b, expected 111/1", out_a, rdy_a);
    end
    #2 rst_a = 1'b0;
    #3;
    vectors++;
    if (out_a !== 3'b000 || rdy_a !== 1'b0) begin
      errors++;
      $display("FAIL glitch_async: out=%b rdy=%b, expected 000/0", out_a, rdy_a);
    end
    rst_a = 1'b1;
    check_powerup("glitch_repeat");
  endtask

  task automatic test_small_params();
    tick();
    rst_b = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      vectors++;
      if (out_b !== (e >= 3) || rdy_b !== (e >= 3) || ack_b !== 1'b0) begin
        errors++;
        $display("FAIL small_pwr E%0d: out=%b rdy=%b ack=%b, expected %0d/%0d/0",
                 e, out_b, rdy_b, ack_b, (e >= 3), (e >= 3));
      end
    end
    req_b = 1'b1;
    tick();
    req_b = 1'b0;
    vectors++;
    if (out_b !== 1'b0 || rdy_b !== 1'b0 || ack_b !== 1'b0) begin
      errors++;
      $display("FAIL small_soft S: out=%b rdy=%b ack=%b, expected 0/0/0", out_b, rdy_b, ack_b);
    end
    tick();
    vectors++;
    if (out_b !== 1'b1 || rdy_b !== 1'b1 || ack_b !== 1'b1) begin
      errors++;
      $display("FAIL small_soft S+1: out=%b rdy=%b ack=%b, expected 1/1/1", out_b, rdy_b, ack_b);
    end
    tick();
    vectors++;
    if (out_b !== 1'b1 || rdy_b !== 1'b1 || ack_b !== 1'b0) begin
      errors++;
      $display("FAIL small_soft S+2: out=%b rdy=%b ack=%b, expected 1/1/0", out_b, rdy_b, ack_b);
    end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    test_reset();
    test_powerup();
    test_soft(1'b0, "soft");
    test_soft(1'b1, "soft_ignored");
    test_reset_mid_soft();
    test_glitch();
    test_small_params();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
